// File: rtl/data_break_responder.sv
// Memory-side responder for single-cycle data-break (DMA) requests from device controllers.
// Owns the memory port for one word per break and yields one instruction slot after BREAK_MAX back-to-back breaks.
module data_break_responder #(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned BREAK_MAX = 4,
  localparam int unsigned ADDR_W   = 15,
  localparam int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inst_boundary,
  input  logic              data_break,
  input  logic              to_disk,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] disk2mem,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem2disk,
  output logic              break_in_prog,
  output logic              break_done
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned LAT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BREAK_MAX);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_YIELD = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] burst_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             yield_hold;
  logic             sync_rst;
  logic             lat_last;
  logic             mem_we_d;
  logic             mem_re_d;
  logic             break_in_prog_d;
  logic             break_done_d;

  assign sync_rst = reset | clear;
  assign lat_last = (lat_cnt == LAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (data_break && inst_boundary) begin
          if (burst_cnt < CNT_MAX) begin
            state_next = S_GRANT;
          end else begin
            state_next = S_YIELD;
          end
        end
      end
      S_GRANT: begin
        if (to_disk) begin
          state_next = S_READ;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_READ:  state_next = S_WAIT;
      S_WAIT: begin
        if (lat_last) begin
          state_next = S_DONE;
        end
      end
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_YIELD: begin
        // leave once the CPU has taken F0, or after two cycles if it is halted
        if (!inst_boundary || yield_hold) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state they belong to
  always_comb begin
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    break_in_prog_d = 1'b0;
    break_done_d    = 1'b0;
    case (state_next)
      S_GRANT, S_WAIT: break_in_prog_d = 1'b1;
      S_READ: begin
        mem_re_d        = 1'b1;
        break_in_prog_d = 1'b1;
      end
      S_WRITE: begin
        mem_we_d        = 1'b1;
        break_in_prog_d = 1'b1;
      end
      S_DONE: begin
        break_done_d    = 1'b1;
        break_in_prog_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, latency counter and fairness counter
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem2disk      <= '0;
      break_in_prog <= 1'b0;
      break_done    <= 1'b0;
      burst_cnt     <= '0;
      lat_cnt       <= '0;
      yield_hold    <= 1'b0;
    end else begin
      mem_we        <= mem_we_d;
      mem_re        <= mem_re_d;
      break_in_prog <= break_in_prog_d;
      break_done    <= break_done_d;
      if (state == S_GRANT) begin
        mem_addr  <= dmaAddr;
        mem_wdata <= disk2mem;
      end
      if (state == S_WAIT) begin
        lat_cnt <= LAT_W'(lat_cnt + 1'b1);
      end else begin
        lat_cnt <= '0;
      end
      if ((state == S_WAIT) && lat_last) begin
        mem2disk <= mem_rdata;
      end
      yield_hold <= (state == S_YIELD) && inst_boundary;
      case (state)
        S_IDLE: begin
          if (!data_break) begin
            burst_cnt <= '0;
          end
        end
        S_DONE: begin
          if (burst_cnt < CNT_MAX) begin
            burst_cnt <= CNT_W'(burst_cnt + 1'b1);
          end
        end
        S_YIELD: burst_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
